// File: rtl/win_check_sequencer.sv
// Win detector for the drop-four game: walks the four line directions through
// the last-placed cell, reading the board RAM one cell per step.
module win_check_sequencer #(
   parameter int COLS    = 7,
   parameter int ROWS    = 6,
   parameter int CELL_W  = 2,
   parameter int WIN_LEN = 4,
   parameter int ADDR_W  = 6
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              check_for_winner,
   input  logic [2:0]        last_col,
   input  logic [2:0]        last_row,
   input  logic              turn,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [CELL_W-1:0] rd_data,
   output logic              busy,
   output logic              done_check_winner,
   output logic              winner
);

   typedef enum logic [2:0] {IDLE, SETUP, STEP, COMPARE, DONE} state_t;

   localparam logic signed [3:0] COLS_S   = 4'(COLS);
   localparam logic signed [3:0] ROWS_S   = 4'(ROWS);
   localparam logic [2:0]        MAX_STEP = 3'(WIN_LEN - 1);
   localparam logic [3:0]        WIN_CNT  = 4'(WIN_LEN);

   state_t            state_q, state_n;
   logic [2:0]        col_q, col_n, row_q, row_n;
   logic [CELL_W-1:0] colour_q, colour_n;
   logic [1:0]        dir_q, dir_n;
   logic              side_q, side_n;      // 0 = adding delta, 1 = subtracting
   logic [2:0]        step_q, step_n;
   logic [3:0]        count_q, count_n, count_inc;
   logic              winner_q, winner_n;
   logic              end_side;

   logic signed [3:0] step_s, off_c, off_r, tgt_c, tgt_r;
   logic              in_range;
   logic [ADDR_W-1:0] tgt_addr;

   // Target cell for the current step; bounds are checked in signed space so
   // stepping off an edge never aliases into a neighbouring row.
   always_comb begin
      step_s = signed'({1'b0, step_q});
      off_c  = (dir_q != 2'd1) ? step_s : 4'sd0;
      if (dir_q == 2'd0)
         off_r = 4'sd0;
      else if (dir_q == 2'd3)
         off_r = -step_s;
      else
         off_r = step_s;
      if (side_q) begin
         off_c = -off_c;
         off_r = -off_r;
      end
      tgt_c    = signed'({1'b0, col_q}) + off_c;
      tgt_r    = signed'({1'b0, row_q}) + off_r;
      in_range = (step_q <= MAX_STEP) &&
                 (tgt_c >= 4'sd0) && (tgt_c < COLS_S) &&
                 (tgt_r >= 4'sd0) && (tgt_r < ROWS_S);
      tgt_addr = ADDR_W'(tgt_r[2:0]) * ADDR_W'(COLS) + ADDR_W'(tgt_c[2:0]);
   end

   assign count_inc = count_q + 4'd1;

   always_comb begin
      state_n  = state_q;
      col_n    = col_q;
      row_n    = row_q;
      colour_n = colour_q;
      dir_n    = dir_q;
      side_n   = side_q;
      step_n   = step_q;
      count_n  = count_q;
      winner_n = winner_q;
      end_side = 1'b0;
      rd_en    = 1'b0;
      rd_addr  = '0;

      case (state_q)
         IDLE: begin
            if (check_for_winner) begin
               col_n    = last_col;
               row_n    = last_row;
               colour_n = turn ? CELL_W'(2) : CELL_W'(1);
               winner_n = 1'b0;
               dir_n    = 2'd0;
               state_n  = SETUP;
            end
         end
         SETUP: begin
            count_n = 4'd1;
            side_n  = 1'b0;
            step_n  = 3'd1;
            state_n = STEP;
         end
         STEP: begin
            if (in_range) begin
               rd_en   = 1'b1;
               rd_addr = tgt_addr;
               state_n = COMPARE;
            end else begin
               end_side = 1'b1;
            end
         end
         COMPARE: begin
            if (rd_data == colour_q) begin
               if (count_inc >= WIN_CNT) begin
                  winner_n = 1'b1;
                  state_n  = DONE;
               end else begin
                  count_n = count_inc;
                  step_n  = step_q + 3'd1;
                  state_n = STEP;
               end
            end else begin
               end_side = 1'b1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // Shared side/direction advance for both out-of-range and colour-miss exits.
      if (end_side) begin
         if (!side_q) begin
            side_n  = 1'b1;
            step_n  = 3'd1;
            state_n = STEP;
         end else if (dir_q != 2'd3) begin
            dir_n   = dir_q + 2'd1;
            state_n = SETUP;
         end else begin
            winner_n = 1'b0;
            state_n  = DONE;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         col_q    <= '0;
         row_q    <= '0;
         colour_q <= '0;
         dir_q    <= '0;
         side_q   <= 1'b0;
         step_q   <= '0;
         count_q  <= '0;
         winner_q <= 1'b0;
      end else begin
         state_q  <= state_n;
         col_q    <= col_n;
         row_q    <= row_n;
         colour_q <= colour_n;
         dir_q    <= dir_n;
         side_q   <= side_n;
         step_q   <= step_n;
         count_q  <= count_n;
         winner_q <= winner_n;
      end
   end

   assign busy              = (state_q != IDLE);
   assign done_check_winner = (state_q == DONE);
   assign winner            = winner_q;

endmodule

// File: tb/tb_win_check_sequencer.sv
// Randomized and directed bench for win_check_sequencer with a board RAM model
// and a line-walking reference that predicts reads, verdict and latency.
module tb_win_check_sequencer;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       check_for_winner;
   logic [2:0] last_col, last_row;
   logic       turn;
   logic       rd_en;
   logic [5:0] rd_addr;
   logic [1:0] rd_data;
   logic       busy, done_check_winner, winner;

   win_check_sequencer #(.COLS(7), .ROWS(6), .CELL_W(2), .WIN_LEN(4), .ADDR_W(6)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .check_for_winner(check_for_winner),
      .last_col(last_col), .last_row(last_row), .turn(turn),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .done_check_winner(done_check_winner), .winner(winner)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   logic [1:0] board [0:41];

   // Synchronous RAM: data only valid the cycle after a strobe, garbage otherwise.
   always @(posedge CLOCK_50)
      rd_data <= (rd_en && rd_addr < 6'd42) ? board[rd_addr] : 2'b11;

   int n_cmp = 0;
   int n_err = 0;

   bit exp_win;
   int exp_idx;
   int exp_q[$];
   int dcs[4] = '{1, 0, 1, 1};
   int drs[4] = '{0, 1, 1, -1};

   task automatic clear_board();
      for (int i = 0; i < 42; i++) board[i] = 2'b00;
   endtask

   task automatic put(input int c, input int r, input logic [1:0] v);
      board[r*7 + c] = v;
   endtask

   // Reference: count contiguous mover cells out from the last piece along each
   // line, recording every cell visited and the cycle at which the verdict lands.
   task automatic model(input int lc, input int lr, input int tn);
      int t, cnt, c, r, sg;
      logic [1:0] col;
      bit stop;
      exp_q.delete();
      exp_win = 0;
      t = 1;
      col = tn ? 2'b10 : 2'b01;
      for (int d = 0; d < 4 && !exp_win; d++) begin
         t++;
         cnt = 1;
         for (int s = 0; s < 2 && !exp_win; s++) begin
            sg = s ? -1 : 1;
            stop = 0;
            for (int st = 1; !stop; st++) begin
               c = lc + sg*st*dcs[d];
               r = lr + sg*st*drs[d];
               if (st >= 4 || c < 0 || c > 6 || r < 0 || r > 5) begin
                  t++;
                  stop = 1;
               end else begin
                  exp_q.push_back(r*7 + c);
                  t += 2;
                  if (board[r*7 + c] == col) begin
                     cnt++;
                     if (cnt >= 4) begin
                        exp_win = 1;
                        stop = 1;
                     end
                  end else begin
                     stop = 1;
                  end
               end
            end
         end
      end
      exp_idx = t;
   endtask

   task automatic run_check(input string name, input int lc, input int lr, input int tn,
                            input int retrig);
      int got_q[$];
      int done_n, done_idx, bad_i;
      bit busy_bad, range_bad, exp_busy;
      model(lc, lr, tn);
      @(negedge CLOCK_50);
      last_col = 3'(lc);
      last_row = 3'(lr);
      turn = tn[0];
      check_for_winner = 1'b1;
      @(posedge CLOCK_50);
      #1 check_for_winner = 1'b0;
      done_n = 0; done_idx = -1; busy_bad = 0; range_bad = 0;
      for (int n = 1; n <= 70; n++) begin
         @(negedge CLOCK_50);
         if (n == retrig) begin
            check_for_winner = 1'b1;
            last_col = 3'($urandom_range(0, 6));
            last_row = 3'($urandom_range(0, 5));
            turn = ~turn;
         end else begin
            check_for_winner = 1'b0;
         end
         exp_busy = (done_idx < 0) || (n == done_idx);
         if (done_check_winner) begin
            done_n++;
            if (done_idx < 0) begin
               done_idx = n;
               exp_busy = 1;
            end
         end
         if (busy !== exp_busy) busy_bad = 1;
         if (rd_en) begin
            got_q.push_back(int'(rd_addr));
            if (rd_addr >= 6'd42) range_bad = 1;
         end
         if (done_idx >= 0 && n >= done_idx + 3) break;
      end
      check_for_winner = 1'b0;

      n_cmp++;
      if (winner !== exp_win) begin
         n_err++;
         $display("FAIL %s winner: got %0b expected %0b", name, winner, exp_win);
      end
      n_cmp++;
      if (done_idx !== exp_idx) begin
         n_err++;
         $display("FAIL %s done_latency: got %0d expected %0d", name, done_idx, exp_idx);
      end
      n_cmp++;
      if (done_n !== 1) begin
         n_err++;
         $display("FAIL %s done_pulses: got %0d expected 1", name, done_n);
      end
      bad_i = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (bad_i < 0 && got_q[i] != exp_q[i]) bad_i = i;
      n_cmp++;
      if (got_q.size() != exp_q.size() || bad_i >= 0) begin
         n_err++;
         $display("FAIL %s read_seq: got %0d reads expected %0d, first diff idx %0d (got %0d expected %0d)",
                  name, got_q.size(), exp_q.size(), bad_i,
                  (bad_i >= 0) ? got_q[bad_i] : -1, (bad_i >= 0) ? exp_q[bad_i] : -1);
      end
      n_cmp++;
      if (range_bad !== 1'b0) begin
         n_err++;
         $display("FAIL %s addr_range: got out-of-board rd_addr, required all < 42", name);
      end
      n_cmp++;
      if (busy_bad !== 1'b0) begin
         n_err++;
         $display("FAIL %s busy_window: got busy outside/inside scan wrongly, required high exactly to DONE", name);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      check_for_winner = 1'b0;
      last_col = '0; last_row = '0; turn = 1'b0;
      clear_board();
      repeat (2) @(negedge CLOCK_50);
      n_cmp++;
      if ({rd_en, rd_addr, busy, done_check_winner, winner} !== 10'b0) begin
         n_err++;
         $display("FAIL reset_values: got rd_en=%b rd_addr=%0d busy=%b done=%b winner=%b required all 0",
                  rd_en, rd_addr, busy, done_check_winner, winner);
      end
      reset = 1'b0;
      repeat (2) @(negedge CLOCK_50);
   endtask

   task automatic test_directed();
      clear_board();
      put(0, 0, 2'b01); put(1, 0, 2'b01); put(2, 0, 2'b01); put(3, 0, 2'b01);
      run_check("horizontal_win", 3, 0, 0, 0);

      clear_board();
      for (int r = 0; r < 4; r++) put(5, r, 2'b10);
      run_check("vertical_win", 5, 3, 1, 0);

      clear_board();
      put(1, 3, 2'b01); put(2, 2, 2'b01); put(3, 1, 2'b01); put(0, 4, 2'b01);
      run_check("diag_down_win", 0, 4, 0, 0);

      clear_board();
      put(6, 5, 2'b01);
      run_check("lone_corner", 6, 5, 0, 0);

      clear_board();
      put(0, 0, 2'b10); put(1, 0, 2'b01); put(2, 0, 2'b01); put(3, 0, 2'b01); put(4, 0, 2'b10);
      run_check("capped_three", 3, 0, 0, 0);
   endtask

   task automatic test_busy_retrigger();
      clear_board();
      put(6, 5, 2'b01);
      run_check("retrigger_nowin", 6, 5, 0, 3);
      clear_board();
      for (int r = 0; r < 4; r++) put(2, r, 2'b10);
      run_check("retrigger_win", 2, 3, 1, 3);
   endtask

   task automatic test_reset_midscan();
      int k, dn;
      clear_board();
      put(3, 2, 2'b01);
      put(4, 2, 2'b01);
      @(negedge CLOCK_50);
      last_col = 3'd3; last_row = 3'd2; turn = 1'b0;
      check_for_winner = 1'b1;
      @(negedge CLOCK_50);
      check_for_winner = 1'b0;
      k = 0;
      while (!rd_en && k < 30) begin
         @(negedge CLOCK_50);
         k++;
      end
      n_cmp++;
      if (!(rd_en === 1'b1 && busy === 1'b1)) begin
         n_err++;
         $display("FAIL midscan_read_wait: got rd_en=%b busy=%b required a read within 30 cycles",
                  rd_en, busy);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({busy, rd_en, rd_addr, done_check_winner, winner} !== 10'b0) begin
         n_err++;
         $display("FAIL midscan_reset: got busy=%b rd_en=%b rd_addr=%0d done=%b winner=%b required all 0",
                  busy, rd_en, rd_addr, done_check_winner, winner);
      end
      repeat (2) @(negedge CLOCK_50);
      reset = 1'b0;
      dn = 0;
      for (int n = 0; n < 70; n++) begin
         @(negedge CLOCK_50);
         if (done_check_winner || busy) dn++;
      end
      n_cmp++;
      if (dn !== 0) begin
         n_err++;
         $display("FAIL midscan_no_done: got %0d busy/done cycles after reset, required 0", dn);
      end

      // Reset landing on the done cycle of a winning scan.
      clear_board();
      for (int c = 0; c < 4; c++) put(c, 1, 2'b10);
      model(0, 1, 1);
      @(negedge CLOCK_50);
      last_col = 3'd0; last_row = 3'd1; turn = 1'b1;
      check_for_winner = 1'b1;
      @(negedge CLOCK_50);
      check_for_winner = 1'b0;
      k = 0;
      while (!done_check_winner && k < 70) begin
         @(negedge CLOCK_50);
         k++;
      end
      n_cmp++;
      if (done_check_winner !== 1'b1 || winner !== exp_win) begin
         n_err++;
         $display("FAIL done_before_reset: got done=%b winner=%b required done=1 winner=%b",
                  done_check_winner, winner, exp_win);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({done_check_winner, winner, busy} !== 3'b000) begin
         n_err++;
         $display("FAIL done_reset: got done=%b winner=%b busy=%b required 0 0 0",
                  done_check_winner, winner, busy);
      end
      @(negedge CLOCK_50);
      reset = 1'b0;
      @(negedge CLOCK_50);

      clear_board();
      for (int c = 2; c < 6; c++) put(c, 4, 2'b01);
      run_check("after_reset", 5, 4, 0, 0);
   endtask

   task automatic test_random();
      int lc, lr, tn, v;
      logic [1:0] mover, other;
      for (int i = 0; i < 40; i++) begin
         tn = $urandom_range(0, 1);
         mover = tn ? 2'b10 : 2'b01;
         other = tn ? 2'b01 : 2'b10;
         for (int j = 0; j < 42; j++) begin
            v = $urandom_range(0, 9);
            board[j] = (v < 5) ? mover : (v < 7) ? other : (v < 9) ? 2'b00 : 2'b11;
         end
         lc = $urandom_range(0, 6);
         lr = $urandom_range(0, 5);
         put(lc, lr, mover);
         run_check("random", lc, lr, tn, (i % 4 == 0) ? 3 : 0);
      end
   endtask

   task automatic test_back_to_back();
      clear_board();
      put(0, 0, 2'b01); put(1, 1, 2'b01); put(2, 2, 2'b01); put(3, 3, 2'b01);
      run_check("b2b_diag_up", 1, 1, 0, 0);
      run_check("b2b_wrong_turn", 1, 1, 1, 0);
      run_check("b2b_edge_col6", 6, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_busy_retrigger();
      test_reset_midscan();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
